// File: rtl/conv_pkg.sv
// Shared types for the 3x3 sliding-window generator.
//   win_state_e : frame sequencing states
//   pixel_t     : one packed pixel word (8 channels x 8 bit)
//   tap_idx     : flat index of window tap (row i, col j), i=0 top, j=0 left
package conv_pkg;

  localparam int unsigned PIXEL_W = 64;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COLPAD,
    FLUSH
  } win_state_e;

  function automatic int unsigned tap_idx(input int unsigned i, input int unsigned j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/conv_window_gen_row_store.sv
// Single-port read-before-write row store (block RAM).
//   clk   : clock
//   en    : perform one access this cycle (read old word, write new word)
//   addr  : word address
//   wdata : word written at addr
//   rdata : previous contents of addr, registered
module row_store #(
  parameter int unsigned DEPTH  = 8192,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator, stride 1, zero padding 1.
//   clk, rst_n             : clock, async active-low reset
//   start, cfg_width/height: frame launch and geometry (sampled on accepted start)
//   pixel/pixel_valid/ready: raster input stream
//   win_data/valid/ready   : 3x3 window output, tap (i,j) at [(3i+j)*DATA_W +: DATA_W]
//   win_last               : marks the window centred on the last pixel
//   busy                   : frame in progress
//
// Pipeline per step: stage A issues the s1 access and latches the bottom pixel,
// stage B issues the s2 access (its write data is the old s1 word just read) and
// holds the middle tap, then the column is shifted into the window register,
// which is also the output register. Every stage advances only when the output
// register is free, so a stall freezes everything.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 8192,
  parameter int unsigned DATA_W    = PIXEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         cfg_width,
  input  logic [15:0]         cfg_height,
  input  logic [DATA_W-1:0]   pixel,
  input  logic                pixel_valid,
  output logic                pixel_ready,
  output logic [9*DATA_W-1:0] win_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                win_last,
  output logic                busy
);

  localparam int unsigned AW = $clog2(MAX_WIDTH);
  localparam int unsigned CW = $clog2(MAX_WIDTH + 1);

  win_state_e      state_q, state_d;
  logic [CW-1:0]   width_q, width_d, col_q, col_d;
  logic [15:0]     height_q, height_d, row_q, row_d;
  logic            flush_done_q, flush_done_d;

  logic            adv, step, ram_col, cfg_ok;

  // Stage A
  logic              a_valid_q, a_ram_q, a_first_q, a_mask_mid_q, a_mask_top_q;
  logic              a_emit_q, a_last_q;
  logic [DATA_W-1:0] a_bot_q;
  logic [AW-1:0]     a_addr_q;

  // Stage B
  logic              b_valid_q, b_top_en_q, b_first_q, b_emit_q, b_last_q;
  logic [DATA_W-1:0] b_mid_q, b_bot_q;

  // Window / output register
  logic [9*DATA_W-1:0] win_q, win_d;
  logic                win_valid_q, win_last_q;

  logic [DATA_W-1:0] s1_rdata, s2_rdata, top_tap;
  logic              s1_en, s2_en;

  assign adv    = !win_valid_q || win_ready;
  assign cfg_ok = (cfg_width != 32'd0) && (cfg_width <= 32'(MAX_WIDTH)) && (cfg_height != 16'd0);

  always_comb begin
    step    = 1'b0;
    ram_col = 1'b0;
    unique case (state_q)
      RUN: begin
        step    = adv && pixel_valid;
        ram_col = 1'b1;
      end
      COLPAD: step = adv;
      FLUSH: begin
        step    = adv && !flush_done_q;
        ram_col = (col_q != width_q);
      end
      default: ;
    endcase
  end

  assign pixel_ready = (state_q == RUN) && adv;
  assign s1_en       = step && ram_col;
  assign s2_en       = adv && a_valid_q && a_ram_q;

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    col_d        = col_q;
    row_d        = row_q;
    flush_done_d = flush_done_q;
    unique case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          width_d      = cfg_width[CW-1:0];
          height_d     = cfg_height;
          col_d        = '0;
          row_d        = '0;
          flush_done_d = 1'b0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (step) begin
          col_d = col_q + 1'b1;
          if (col_q == width_q - 1'b1) state_d = COLPAD;
        end
      end
      COLPAD: begin
        if (step) begin
          col_d   = '0;
          row_d   = row_q + 16'd1;
          state_d = (row_q < height_q - 16'd1) ? RUN : FLUSH;
        end
      end
      FLUSH: begin
        if (step) begin
          if (col_q == width_q) flush_done_d = 1'b1;
          else                  col_d        = col_q + 1'b1;
        end
        if (win_valid_q && win_ready && win_last_q) begin
          state_d      = IDLE;
          col_d        = '0;
          row_d        = '0;
          flush_done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      col_q        <= col_d;
      row_q        <= row_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Rows above the frame are masked by the row counter instead of clearing RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q    <= 1'b0;
      a_ram_q      <= 1'b0;
      a_first_q    <= 1'b0;
      a_mask_mid_q <= 1'b0;
      a_mask_top_q <= 1'b0;
      a_emit_q     <= 1'b0;
      a_last_q     <= 1'b0;
      a_bot_q      <= '0;
      a_addr_q     <= '0;
    end else if (adv) begin
      a_valid_q <= step;
      if (step) begin
        a_ram_q      <= ram_col;
        a_first_q    <= (col_q == '0);
        a_mask_mid_q <= (row_q == 16'd0);
        a_mask_top_q <= (row_q < 16'd2);
        a_emit_q     <= (row_q != 16'd0) && (col_q != '0);
        a_last_q     <= (row_q == height_q) && (col_q == width_q);
        a_bot_q      <= (state_q == RUN) ? pixel : '0;
        a_addr_q     <= col_q[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_q  <= 1'b0;
      b_top_en_q <= 1'b0;
      b_first_q  <= 1'b0;
      b_emit_q   <= 1'b0;
      b_last_q   <= 1'b0;
      b_mid_q    <= '0;
      b_bot_q    <= '0;
    end else if (adv) begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        b_top_en_q <= a_ram_q && !a_mask_top_q;
        b_first_q  <= a_first_q;
        b_emit_q   <= a_emit_q;
        b_last_q   <= a_last_q;
        b_mid_q    <= (a_ram_q && !a_mask_mid_q) ? s1_rdata : '0;
        b_bot_q    <= a_bot_q;
      end
    end
  end

  assign top_tap = b_top_en_q ? s2_rdata : '0;

  // Shift the new column in on the right; the first column of a row also
  // clears the two older columns so column -1 reads as padding.
  always_comb begin
    win_d = win_q;
    if (adv && b_valid_q) begin
      for (int i = 0; i < 3; i++) begin
        win_d[tap_idx(i, 0)*DATA_W +: DATA_W] =
            b_first_q ? '0 : win_q[tap_idx(i, 1)*DATA_W +: DATA_W];
        win_d[tap_idx(i, 1)*DATA_W +: DATA_W] =
            b_first_q ? '0 : win_q[tap_idx(i, 2)*DATA_W +: DATA_W];
      end
      win_d[tap_idx(0, 2)*DATA_W +: DATA_W] = top_tap;
      win_d[tap_idx(1, 2)*DATA_W +: DATA_W] = b_mid_q;
      win_d[tap_idx(2, 2)*DATA_W +: DATA_W] = b_bot_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      if (adv) begin
        win_valid_q <= b_valid_q && b_emit_q;
        win_last_q  <= b_valid_q && b_last_q;
      end
    end
  end

  assign win_data  = win_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign busy      = (state_q != IDLE);

  row_store #(
    .DEPTH  (MAX_WIDTH),
    .ADDR_W (AW),
    .DATA_W (DATA_W)
  ) u_s1 (
    .clk   (clk),
    .en    (s1_en),
    .addr  (col_q[AW-1:0]),
    .wdata (a_bot_d_unused_guard(pixel)),
    .rdata (s1_rdata)
  );

  // s2 is accessed one cycle after s1 for the same column, so the old s1 word
  // it must inherit is already on s1_rdata.
  row_store #(
    .DEPTH  (MAX_WIDTH),
    .ADDR_W (AW),
    .DATA_W (DATA_W)
  ) u_s2 (
    .clk   (clk),
    .en    (s2_en),
    .addr  (a_addr_q),
    .wdata (s1_rdata),
    .rdata (s2_rdata)
  );

  // FLUSH steps write zero into s1; the value is never read back within the frame.
  function automatic logic [DATA_W-1:0] a_bot_d_unused_guard(input logic [DATA_W-1:0] p);
    return (state_q == RUN) ? p : '0;
  endfunction

endmodule
